gpio_port_ctrl: RTL and testbench
=================================

# gpio_port_ctrl

Parametrised Avalon-MM GPIO controller for the PCM-player Qsys cores. It replaces the fixed 2-bit bidirectional PIO and generalises it to WIDTH pins. Each pin gets direction control, atomic set/clear of outputs, a two-flop input synchroniser and an optional debounce filter. Inputs also feed an edge-capture register with per-bit interrupt masking and a level IRQ output to the CPU.

## Interface

Parameters:
- WIDTH, 2: pin count, 1..32.
- EDGE_TYPE, 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.
- DEBOUNCE, 0: cycles an input must be stable before it is accepted. 0 disables the filter; maximum 65535.
- RESET_OUT, 0: reset value of data_out, WIDTH bits.
- RESET_DIR, 0: reset value of data_dir, WIDTH bits. 1 = output.

Ports:
- clk, input, 1: system clock. One clock for the whole block.
- reset, input, 1: reset, synchronous, active-high.
- address, input, 3: register word address.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data. Bits above WIDTH are ignored.
- readdata, output, 32: registered read data. Bits above WIDTH read 0.
- irq, output, 1: level interrupt.
- bidir_port, inout, WIDTH: device pins.

## Operation

A write is `chipselect & ~write_n`. Register map:
- 0 DATA
  - read: filtered input value `in_f`.
  - write: loads data_out.
- 1 DIR
  - read/write: data_dir.
- 2 IRQMASK
  - read/write: irq_mask.
- 3 EDGECAP
  - read: capture.
  - write: each 1 bit clears the matching capture bit (write-1-to-clear).
- 4 OUTSET
  - write: `data_out <= data_out | wd`.
  - read: returns data_out.
- 5 OUTCLR
  - write: `data_out <= data_out & ~wd`.
  - read: returns data_out.
- 6, 7: read 0; writes are ignored.

Pin drive:
- `bidir_port[i] = data_dir[i] ? data_out[i] : Z`.
- Inputs are always sampled, including pins driven as outputs, so a driven pin reads back its own level.

Input path, per bit:
- The pin passes through a 2-flop synchroniser, giving `in_s`.
- DEBOUNCE = 0: `in_f` follows `in_s`, registered, one cycle.
- DEBOUNCE = N > 0: each bit has a counter.
  - While `in_s != in_f`, the counter increments every cycle.
  - When the counter reaches N-1 with `in_s` still different, `in_f <= in_s` and the counter clears.
  - Any cycle with `in_s == in_f` clears the counter.
  - A pulse shorter than N cycles never reaches `in_f`.

Edge detect:
- Compares `in_f` with its previous value `in_f_d`.
- rise = `in_f & ~in_f_d`; fall = `~in_f & in_f_d`.
- `ev` is selected from rise/fall by EDGE_TYPE.
- `capture <= (capture & ~clr) | ev`, where clr is the EDGECAP write-1 mask. A new event wins over a clear in the same cycle.

Interrupt:
- `irq = |(capture & irq_mask)`, driven from registers only.
- Masking a bit does not stop it being captured.

Arming:
- After reset, edge detection stays disabled for 3 cycles, covering synchroniser plus filter fill.
- While disarmed, `in_f` and `in_f_d` load directly from `in_s` with no debounce delay.
- This prevents spurious events from pins that sit high at reset.

Reset values:
- data_out = RESET_OUT; data_dir = RESET_DIR.
- irq_mask = 0; capture = 0.
- Synchroniser, in_f, in_f_d and counters = 0.
- readdata = 0; irq = 0.
- Asserting reset mid-debounce or mid-capture discards all pending state on the next edge.

## Timing

- readdata is registered every cycle from the current address; chipselect is not required. Read latency is 1 cycle.
- A write takes effect at the clock edge it is presented on. A read of the same register on the next cycle returns the new value.
- Pin to `in_s`: 2 cycles. Pin to `in_f`: 3 cycles with DEBOUNCE = 0, otherwise 2 + N cycles.
- `in_f` to capture bit: 1 cycle. irq is valid the same cycle capture sets.
- Pin to irq is 4 cycles minimum.
- Writes to OUTSET/OUTCLR and DATA affect bidir_port the cycle after the write edge.

## Test plan

- Reset with RESET_DIR=2'b01, RESET_OUT=2'b01 -> pin0 driven 1, pin1 Z, readdata=0, irq=0. A read of address 1 returns 1 after 1 cycle.
- WIDTH=8: write DATA=0x0F, then OUTSET 0xC0, then OUTCLR 0x03 -> data_out=0xCC. Reading address 4 returns 0xCC.
- EDGE_TYPE=0, mask=0x01: pin0 rises -> EDGECAP=0x01 and irq=1 four cycles after the pin changes. Write EDGECAP=0x01 -> irq=0 next cycle.
- Same-cycle EDGECAP clear and new rising event on bit 0 -> capture bit remains 1.
- DEBOUNCE=4: 3-cycle high glitch on pin -> `in_f` unchanged, no capture. A 4-cycle high pulse -> `in_f`=1 at pin+6 cycles and capture set.
- Pin held high through reset release with EDGE_TYPE=0 -> DATA reads 1 and EDGECAP stays 0.

Source files
------------

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: WIDTH-pin bidirectional GPIO on an Avalon-MM slave.
// Per-pin direction, atomic set/clear of outputs, 2-flop input synchroniser,
// optional debounce filter, edge capture with per-bit IRQ mask.
module gpio_port_ctrl #(
    parameter int unsigned      WIDTH     = 2,
    parameter int unsigned      EDGE_TYPE = 0,
    parameter int unsigned      DEBOUNCE  = 0,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    parameter logic [WIDTH-1:0] RESET_DIR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    typedef enum logic [1:0] {ARM_0, ARM_1, ARM_2, ARMED} arm_t;

    arm_t             arm_q, arm_d;
    logic             armed;
    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out, data_dir, irq_mask, capture;
    logic [WIDTH-1:0] sync0, in_s, in_f, in_f_d;
    logic [WIDTH-1:0] rise, fall, ev, clr;
    logic [31:0]      rd_mux;
    logic             unused_ok;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_ok = &{1'b0, writedata};

    // Pin drivers: output-enabled pins drive data_out, others float
    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        assign bidir_port[g] = data_dir[g] ? data_out[g] : 1'bz;
    end

    // Arming state register
    always_ff @(posedge clk) begin
        if (reset) arm_q <= ARM_0;
        else       arm_q <= arm_d;
    end

    // Arming sequence: three disarmed cycles after reset, then armed for good
    always_comb begin
        arm_d = arm_q;
        armed = 1'b0;
        case (arm_q)
            ARM_0:   arm_d = ARM_1;
            ARM_1:   arm_d = ARM_2;
            ARM_2:   arm_d = ARMED;
            ARMED:   armed = 1'b1;
            default: arm_d = ARM_0;
        endcase
    end

    // Control registers: DATA, DIR, IRQMASK and the OUTSET/OUTCLR aliases
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= RESET_OUT;
            data_dir <= RESET_DIR;
            irq_mask <= '0;
        end else if (wr_en) begin
            case (address)
                3'd0:    data_out <= wd;
                3'd1:    data_dir <= wd;
                3'd2:    irq_mask <= wd;
                3'd4:    data_out <= data_out | wd;
                3'd5:    data_out <= data_out & ~wd;
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser on every pin, driven or not
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= '0;
            in_s  <= '0;
        end else begin
            sync0 <= bidir_port;
            in_s  <= sync0;
        end
    end

    if (DEBOUNCE == 0) begin : g_nofilt
        // Unfiltered path: one register stage after the synchroniser
        always_ff @(posedge clk) begin
            if (reset) in_f <= '0;
            else       in_f <= in_s;
        end
    end else begin : g_filt
        localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE - 1);
        logic [15:0] cnt [WIDTH];

        // Per-bit stability counters; a change is accepted after DEBOUNCE cycles
        always_ff @(posedge clk) begin
            if (reset) begin
                in_f <= '0;
                for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
            end else if (!armed) begin
                in_f <= in_s;
                for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
            end else begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (in_s[i] != in_f[i]) begin
                        if (cnt[i] == CNT_MAX) begin
                            in_f[i] <= in_s[i];
                            cnt[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 16'd1;
                        end
                    end else begin
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Previous filtered value; tracks in_s while disarmed so no edge is seen at arming
    always_ff @(posedge clk) begin
        if (reset)       in_f_d <= '0;
        else if (!armed) in_f_d <= in_s;
        else             in_f_d <= in_f;
    end

    assign rise = in_f & ~in_f_d;
    assign fall = ~in_f & in_f_d;
    assign clr  = (wr_en && address == 3'd4 - 3'd1) ? wd : '0;

    // Edge event selection, suppressed while disarmed
    always_comb begin
        ev = '0;
        if (armed) begin
            case (EDGE_TYPE)
                0:       ev = rise;
                1:       ev = fall;
                default: ev = rise | fall;
            endcase
        end
    end

    // Edge capture with write-1-to-clear; a new event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) capture <= '0;
        else       capture <= (capture & ~clr) | ev;
    end

    assign irq = |(capture & irq_mask);

    // Read mux; unused upper bits read as zero
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux[WIDTH-1:0] = in_f;
            3'd1:    rd_mux[WIDTH-1:0] = data_dir;
            3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            3'd3:    rd_mux[WIDTH-1:0] = capture;
            3'd4:    rd_mux[WIDTH-1:0] = data_out;
            3'd5:    rd_mux[WIDTH-1:0] = data_out;
            default: ;
        endcase
    end

    // Registered read data, updated every cycle from the current address
    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Scoreboard bench for gpio_port_ctrl: three configurations on a shared bus.
`timescale 1ns/1ps
module tb_gpio_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        cs_a, cs_b, cs_c;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;
    wire  [1:0]  pins_a;
    wire  [7:0]  pins_b;
    wire  [3:0]  pins_c;
    logic        drv_a1;
    logic [7:0]  drv_b;
    logic [3:0]  drv_c;
    logic        rd_req;
    logic        stim_done;

    typedef struct {
        int          dut;
        logic [31:0] exp_rd;
        bit          chk_irq;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t        sb[$];
    vec_t        v;
    logic [31:0] act_rd;
    logic        act_irq;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign pins_a[1] = drv_a1;
    assign pins_b    = drv_b;
    assign pins_c    = drv_c;

    gpio_port_ctrl #(.WIDTH(2), .EDGE_TYPE(0), .DEBOUNCE(0),
                     .RESET_OUT(2'b01), .RESET_DIR(2'b01)) u_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .irq(irq_a), .bidir_port(pins_a));

    gpio_port_ctrl #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE(0),
                     .RESET_OUT(8'h00), .RESET_DIR(8'h00)) u_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .irq(irq_b), .bidir_port(pins_b));

    gpio_port_ctrl #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE(4),
                     .RESET_OUT(4'h0), .RESET_DIR(4'h0)) u_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_c),
        .write_n(write_n), .writedata(writedata), .readdata(rd_c),
        .irq(irq_c), .bidir_port(pins_c));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int dut, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs_a      = (dut == 0);
        cs_b      = (dut == 1);
        cs_c      = (dut == 2);
        @(negedge clk);
        write_n = 1'b1;
        cs_a    = 1'b0;
        cs_b    = 1'b0;
        cs_c    = 1'b0;
    endtask

    // Queue the expectation, then present the read for the next clock edge.
    task automatic chk(input int dut, input logic [2:0] a, input logic [31:0] e,
                       input bit ci, input logic ei, input string nm);
        vec_t t;
        t.dut = dut; t.exp_rd = e; t.chk_irq = ci; t.exp_irq = ei; t.name = nm;
        sb.push_back(t);
        address = a;
        rd_req  = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Monitor: a read presented at an edge shows up on readdata just after it.
    always @(posedge clk) begin
        if (stim_done) begin
            if (sb.size() != 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_leftover: %0d entries remain, required 0", sb.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end else if (rd_req) begin
            #1;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: read seen with no expectation queued");
            end else begin
                v       = sb.pop_front();
                act_rd  = (v.dut == 0) ? rd_a  : (v.dut == 1) ? rd_b  : rd_c;
                act_irq = (v.dut == 0) ? irq_a : (v.dut == 1) ? irq_b : irq_c;
                n_vec++;
                if (act_rd !== v.exp_rd) begin
                    n_err++;
                    $display("FAIL %s readdata: got %h, required %h", v.name, act_rd, v.exp_rd);
                end
                if (v.chk_irq) begin
                    n_vec++;
                    if (act_irq !== v.exp_irq) begin
                        n_err++;
                        $display("FAIL %s irq: got %b, required %b", v.name, act_irq, v.exp_irq);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; address = '0; write_n = 1'b1; writedata = '0;
        cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
        rd_req = 1'b0; stim_done = 1'b0;
        drv_a1 = 1'b0; drv_b = 8'h01; drv_c = 4'h0;
        @(negedge clk);
        tick(2);

        // Reset state
        chk(0, 3'd1, 32'h0, 1, 1'b0, "rst_a");
        chk(1, 3'd0, 32'h0, 1, 1'b0, "rst_b");
        chk(2, 3'd4, 32'h0, 1, 1'b0, "rst_c");
        reset = 1'b0;

        // Reset values of DIR/DATA_OUT and driven pin readback
        chk(0, 3'd1, 32'h1, 1, 1'b0, "a_dir_rst");
        chk(0, 3'd4, 32'h1, 0, 1'b0, "a_out_rst");
        tick(4);
        chk(0, 3'd0, 32'h1, 0, 1'b0, "a_pin0_readback");
        // Pin held high through reset: no spurious capture
        chk(1, 3'd0, 32'h1, 0, 1'b0, "b_pin_high_thru_rst");
        chk(1, 3'd3, 32'h0, 1, 1'b0, "b_no_spurious_cap");

        // DATA / OUTSET / OUTCLR
        wr(1, 3'd0, 32'h0F);
        wr(1, 3'd4, 32'hC0);
        wr(1, 3'd5, 32'h03);
        chk(1, 3'd4, 32'hCC, 0, 1'b0, "b_outset_rd");
        chk(1, 3'd5, 32'hCC, 0, 1'b0, "b_outclr_rd");
        chk(1, 3'd0, 32'h01, 0, 1'b0, "b_data_reads_pins");
        wr(1, 3'd2, 32'hFFFF_FF01);
        chk(1, 3'd2, 32'h01, 0, 1'b0, "b_mask_upper_ignored");
        wr(1, 3'd6, 32'hFFFF_FFFF);
        chk(1, 3'd6, 32'h0, 0, 1'b0, "b_addr6_zero");
        chk(1, 3'd1, 32'h0, 0, 1'b0, "b_dir_untouched");
        chk(1, 3'd4, 32'hCC, 0, 1'b0, "b_out_untouched");

        // Rising-edge capture and pin-to-irq latency
        drv_b = 8'h00;
        tick(6);
        chk(1, 3'd3, 32'h0, 1, 1'b0, "b_fall_ignored");
        drv_b = 8'h01;
        tick(2);
        chk(1, 3'd2, 32'h01, 1, 1'b0, "b_irq_pin_plus3");
        chk(1, 3'd2, 32'h01, 1, 1'b1, "b_irq_pin_plus4");
        chk(1, 3'd3, 32'h01, 1, 1'b1, "b_cap_set");

        // Clear coinciding with a new event keeps the bit
        drv_b = 8'h00;
        tick(6);
        chk(1, 3'd3, 32'h01, 1, 1'b1, "b_cap_held");
        drv_b = 8'h01;
        tick(3);
        wr(1, 3'd3, 32'h01);
        chk(1, 3'd3, 32'h01, 1, 1'b1, "b_clr_vs_event");
        wr(1, 3'd3, 32'h01);
        chk(1, 3'd3, 32'h0, 1, 1'b0, "b_cap_cleared");

        // Unmasked bit is captured but raises no irq
        drv_b = 8'h03;
        tick(6);
        chk(1, 3'd3, 32'h02, 1, 1'b0, "b_unmasked_cap");
        wr(1, 3'd3, 32'hFF);
        chk(1, 3'd3, 32'h0, 1, 1'b0, "b_clr_all");

        // OUTCLR reaches the pin and reads back through the synchroniser
        wr(0, 3'd5, 32'h1);
        tick(4);
        chk(0, 3'd0, 32'h0, 0, 1'b0, "a_pin0_cleared");

        // Debounce: 3-cycle glitch rejected
        drv_c = 4'h1;
        tick(3);
        drv_c = 4'h0;
        tick(8);
        chk(2, 3'd0, 32'h0, 1, 1'b0, "c_glitch_data");
        chk(2, 3'd3, 32'h0, 1, 1'b0, "c_glitch_nocap");

        // Debounce: 4-cycle pulse accepted at pin+6
        drv_c = 4'h1;
        tick(4);
        drv_c = 4'h0;
        tick(1);
        chk(2, 3'd0, 32'h0, 0, 1'b0, "c_inf_pin_plus5");
        chk(2, 3'd0, 32'h1, 0, 1'b0, "c_inf_pin_plus6");
        chk(2, 3'd3, 32'h1, 1, 1'b0, "c_cap_masked_no_irq");
        tick(6);
        wr(2, 3'd3, 32'h1);
        chk(2, 3'd3, 32'h0, 1, 1'b0, "c_cap_clr");

        // Any-edge mode captures a falling edge
        wr(2, 3'd2, 32'h1);
        drv_c = 4'h1;
        tick(10);
        wr(2, 3'd3, 32'hF);
        chk(2, 3'd3, 32'h0, 1, 1'b0, "c_cap_clr2");
        drv_c = 4'h0;
        tick(10);
        chk(2, 3'd3, 32'h1, 1, 1'b1, "c_fall_cap_irq");

        tick(2);
        stim_done = 1'b1;
    end

endmodule
